// File: rtl/ram_seq_master_pkg.sv
// Shared definitions for the RAM sequencing initiator: op codes, FSM states
// and the fill/check data pattern.
package ram_seq_master_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_CHECK = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_FILL,
        S_CHECK,
        S_RESP
    } state_t;

    // Callers truncate the result to their data width, giving (seed + addr) mod 2^DW.
    function automatic logic [31:0] pattern(input logic [31:0] seed, input logic [31:0] addr);
        return seed + addr;
    endfunction

endpackage

// File: rtl/ram_seq_master.sv
// Command-driven initiator for a small word RAM: single write/read plus
// whole-array pattern fill and check, with a one-cycle response pulse.
module ram_seq_master
    import ram_seq_master_pkg::*;
#(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] rsp_err_addr,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t        state, next_state;
    logic [1:0]    op_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] seed_q;
    logic [AW-1:0] cnt_q;
    logic          err_q;
    logic [AW-1:0] err_addr_q;
    logic [DW-1:0] err_data_q;
    logic [DW-1:0] pat;
    logic          last;
    logic          miss;
    logic          rsp_load;

    assign pat      = DW'(pattern(32'(seed_q), 32'(cnt_q)));
    assign last     = (cnt_q == {AW{1'b1}});
    assign miss     = (state == S_CHECK) && (mem_rdata != pat);
    assign rsp_load = (state != S_RESP) && (next_state == S_RESP);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: next_state = S_WRITE;
                        OP_READ:  next_state = S_READ;
                        OP_FILL:  next_state = S_FILL;
                        default:  next_state = S_CHECK;
                    endcase
                end
            end
            S_WRITE, S_READ:  next_state = S_RESP;
            // Terminate on the last address rather than counter overflow.
            S_FILL, S_CHECK:  if (last) next_state = S_RESP;
            S_RESP:           next_state = S_IDLE;
            default:          next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_WRITE: begin
                mem_rw    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = seed_q;
            end
            S_READ:  mem_addr = addr_q;
            S_FILL: begin
                mem_rw    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = pat;
            end
            S_CHECK: mem_addr = cnt_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            op_q         <= '0;
            addr_q       <= '0;
            seed_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            err_addr_q   <= '0;
            err_data_q   <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            rsp_err_addr <= '0;
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                op_q       <= cmd_op;
                addr_q     <= cmd_addr;
                seed_q     <= cmd_wdata;
                cnt_q      <= '0;
                err_q      <= 1'b0;
                err_addr_q <= '0;
                err_data_q <= '0;
            end
            if (state == S_FILL || state == S_CHECK)
                cnt_q <= cnt_q + 1'b1;
            // Only the first mismatch of a scan is kept.
            if (miss && !err_q) begin
                err_q      <= 1'b1;
                err_addr_q <= cnt_q;
                err_data_q <= mem_rdata;
            end
            if (rsp_load) begin
                rsp_rdata    <= '0;
                rsp_err      <= 1'b0;
                rsp_err_addr <= '0;
                case (op_q)
                    OP_READ: rsp_rdata <= mem_rdata;
                    OP_CHECK: begin
                        // A mismatch on the final address has not reached err_q yet.
                        if (err_q) begin
                            rsp_rdata    <= err_data_q;
                            rsp_err      <= 1'b1;
                            rsp_err_addr <= err_addr_q;
                        end else if (miss) begin
                            rsp_rdata    <= mem_rdata;
                            rsp_err      <= 1'b1;
                            rsp_err_addr <= cnt_q;
                        end else begin
                            rsp_rdata    <= mem_rdata;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_seq_master.sv
// Randomised bench for ram_seq_master: an 8x8 RAM on the bus plus an
// array-level reference model of the expected RAM contents and responses.
module tb_ram_seq_master;
    import ram_seq_master_pkg::*;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_addr = 3'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [2:0] rsp_err_addr;
    logic       mem_rw;
    logic [2:0] mem_addr;
    logic [7:0] mem_wdata;
    wire  [7:0] ram_dout;

    logic [7:0] ram     [8];
    logic [7:0] ref_mem [8];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_seq_master #(.AW(3), .DW(8)) dut (
        .clk(clk), .clr(clr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_err_addr(rsp_err_addr),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(ram_dout)
    );

    assign ram_dout = mem_rw ? 8'hzz : ram[mem_addr];

    always @(posedge clk) if (mem_rw) ram[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    // Issue one command, update the reference model and check bus and response.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] a, input logic [7:0] d);
        logic [7:0] e_rdata;
        logic       e_err;
        logic [2:0] e_eaddr;
        int         e_lat;
        int         lat;
        logic       e_rw;
        e_rdata = 8'd0; e_err = 1'b0; e_eaddr = 3'd0; e_lat = 2;
        case (op)
            OP_WRITE: ref_mem[a] = d;
            OP_READ:  e_rdata = ref_mem[a];
            OP_FILL: begin
                e_lat = 9;
                for (int i = 0; i < 8; i++) ref_mem[i] = 8'(d + i);
            end
            default: begin
                e_lat = 9;
                for (int i = 0; i < 8; i++)
                    if (!e_err && ref_mem[i] != 8'(d + i)) begin
                        e_err = 1'b1; e_eaddr = 3'(i); e_rdata = ref_mem[i];
                    end
                if (!e_err) e_rdata = ref_mem[7];
            end
        endcase
        e_rw = (op == OP_WRITE || op == OP_FILL);

        wait_ready();
        chk("idle_bus", {mem_rw, mem_addr, mem_wdata}, 32'd0);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
            chk("bus_rw", 32'(mem_rw), 32'(e_rw));
            chk("bus_addr", 32'(mem_addr), (op == OP_WRITE || op == OP_READ) ? 32'(a) : 32'(k - 1));
            if (op == OP_WRITE) chk("bus_wdata", 32'(mem_wdata), 32'(d));
            if (op == OP_FILL)  chk("bus_wdata", 32'(mem_wdata), 32'(8'(d + k - 1)));
        end
        chk("latency", 32'(lat), 32'(e_lat));
        if (lat != 0) begin
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
            chk("rsp_err", 32'(rsp_err), 32'(e_err));
            chk("rsp_err_addr", 32'(rsp_err_addr), 32'(e_eaddr));
            chk("resp_bus_rw", 32'(mem_rw), 32'd0);
            @(negedge clk);
            chk("rsp_pulse", {rsp_valid, cmd_ready}, 32'b01);
            chk("rsp_hold", 32'(rsp_rdata), 32'(e_rdata));
        end
    endtask

    initial begin
        int pulses;
        int fill_k;
        int acc_k;
        int read_k;
        logic [7:0] last_seed;
        logic [1:0] rop;

        for (int i = 0; i < 8; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_err_addr, rsp_rdata}, 32'd0);
        chk("rst_bus", {mem_rw, mem_addr, mem_wdata}, 32'd0);
        clr = 1'b0;

        // Directed sequence from the test plan
        run_cmd(OP_WRITE, 3'd5, 8'h3C);
        run_cmd(OP_READ,  3'd5, 8'h00);
        run_cmd(OP_FILL,  3'd0, 8'hFE);
        for (int i = 0; i < 8; i++) chk("fill_ram", 32'(ram[i]), 32'(8'(8'hFE + i)));
        run_cmd(OP_CHECK, 3'd0, 8'hFE);
        run_cmd(OP_FILL,  3'd0, 8'h10);
        run_cmd(OP_WRITE, 3'd3, 8'h00);
        run_cmd(OP_WRITE, 3'd6, 8'hFF);
        run_cmd(OP_CHECK, 3'd0, 8'h10);

        // READ held behind FILL: accepted exactly one cycle after FILL's response
        wait_ready();
        cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_addr = 3'd0; cmd_wdata = 8'h41;
        @(posedge clk);
        #1 cmd_op = OP_READ; cmd_addr = 3'd2;
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'(8'h41 + i);
        pulses = 0; fill_k = 0; acc_k = 0; read_k = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                pulses++;
                if (fill_k == 0) fill_k = k;
                else begin
                    read_k = k;
                    chk("b2b_rdata", 32'(rsp_rdata), 32'(ref_mem[2]));
                end
            end
            if (cmd_ready && cmd_valid && acc_k == 0) begin
                acc_k = k;
                @(posedge clk);
                #1 cmd_valid = 1'b0;
            end
        end
        chk("b2b_fill_lat", 32'(fill_k), 32'd9);
        chk("b2b_accept", 32'(acc_k), 32'd10);
        chk("b2b_read_lat", 32'(read_k), 32'd12);
        chk("b2b_pulses", 32'(pulses), 32'd2);

        // Reset on the 4th cycle of a FILL: addresses 0..2 written, rest untouched
        wait_ready();
        cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_wdata = 8'hA0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("clr_bus", {mem_rw, mem_addr, mem_wdata}, 32'd0);
        chk("clr_ready", 32'(cmd_ready), 32'd1);
        chk("clr_rsp", {rsp_valid, rsp_err, rsp_err_addr, rsp_rdata}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        chk("clr_no_rsp", 32'(pulses), 32'd0);
        for (int i = 0; i < 3; i++) ref_mem[i] = 8'(8'hA0 + i);
        for (int i = 0; i < 8; i++) run_cmd(OP_READ, 3'(i), 8'h00);

        // Random traffic; CHECK mostly reuses the last fill seed so both outcomes occur
        last_seed = 8'hA0;
        for (int n = 0; n < 150; n++) begin
            rop = 2'($urandom_range(0, 3));
            if (rop == OP_FILL) begin
                last_seed = 8'($urandom);
                run_cmd(OP_FILL, 3'd0, last_seed);
            end else if (rop == OP_CHECK) begin
                run_cmd(OP_CHECK, 3'($urandom), ($urandom_range(0, 3) != 0) ? last_seed : 8'($urandom));
            end else if (rop == OP_WRITE) begin
                // Often rewrite the expected value so CHECKs can still pass
                logic [2:0] wa;
                wa = 3'($urandom);
                run_cmd(OP_WRITE, wa, ($urandom_range(0, 1) != 0) ? 8'(last_seed + wa) : 8'($urandom));
            end else begin
                run_cmd(OP_READ, 3'($urandom), 8'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
